// File: rtl/clk_div_phase.sv
// Runtime-programmable divided clock with four phase strobes for an I2C SCL path.
// Supports SCL stretching at the rise point and a clean stop at the period boundary.
module clk_div_phase #(
  parameter int unsigned CNT_W       = 16,
  parameter int unsigned DIV_DEFAULT = 500,
  parameter logic        IDLE_LVL    = 1'b1
) (
  input  logic             clk_i,
  input  logic             arstn_i,
  input  logic             en_i,
  input  logic [CNT_W-1:0] div_i,
  input  logic             div_we_i,
  input  logic             stretch_i,
  output logic             clk_o,
  output logic             fall_o,
  output logic             low_mid_o,
  output logic             rise_o,
  output logic             high_mid_o,
  output logic             busy_o,
  output logic [1:0]       dbg_state_o
);

  localparam int unsigned      DIV_MIN   = 4;
  localparam logic [CNT_W-1:0] DIV_MIN_W = CNT_W'(DIV_MIN);
  localparam logic [CNT_W-1:0] DIV_RST   = CNT_W'((DIV_DEFAULT < DIV_MIN) ? DIV_MIN : DIV_DEFAULT);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_STOP = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] div_q, div_d;
  logic [CNT_W-1:0] pend_q, pend_d;
  logic             pend_v_q, pend_v_d;
  logic             clk_q, clk_d;
  logic             fall_q, fall_d;
  logic             lmid_q, lmid_d;
  logic             rise_q, rise_d;
  logic             hmid_q, hmid_d;
  logic             busy_q, busy_d;
  logic             apply;

  logic [CNT_W-1:0] half, quarter, last, hq, cnt_inc;

  assign half    = div_q >> 1;
  assign quarter = div_q >> 2;
  assign last    = div_q - 1'b1;
  assign hq      = half + quarter;
  assign cnt_inc = cnt_q + 1'b1;

  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      div_q    <= DIV_RST;
      pend_q   <= DIV_RST;
      pend_v_q <= 1'b0;
      clk_q    <= IDLE_LVL;
      fall_q   <= 1'b0;
      lmid_q   <= 1'b0;
      rise_q   <= 1'b0;
      hmid_q   <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      div_q    <= div_d;
      pend_q   <= pend_d;
      pend_v_q <= pend_v_d;
      clk_q    <= clk_d;
      fall_q   <= fall_d;
      lmid_q   <= lmid_d;
      rise_q   <= rise_d;
      hmid_q   <= hmid_d;
      busy_q   <= busy_d;
    end
  end

  // Outputs are registered from the decode of the next count value.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    div_d    = div_q;
    pend_d   = pend_q;
    pend_v_d = pend_v_q;
    clk_d    = clk_q;
    fall_d   = 1'b0;
    lmid_d   = 1'b0;
    rise_d   = 1'b0;
    hmid_d   = 1'b0;
    busy_d   = busy_q;
    apply    = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        clk_d = IDLE_LVL;
        apply = pend_v_q;
        if (en_i) begin
          state_d = ST_RUN;
          clk_d   = 1'b0;
          fall_d  = 1'b1;
        end
      end
      default: begin
        state_d = en_i ? ST_RUN : ST_STOP;
        if ((cnt_q == half) && stretch_i) begin
          // Frozen at the rise point: hold high, no strobe re-fires.
          cnt_d = cnt_q;
          clk_d = 1'b1;
        end else if (cnt_q == last) begin
          cnt_d = '0;
          if (en_i) begin
            clk_d  = 1'b0;
            fall_d = 1'b1;
            apply  = pend_v_q;
          end else begin
            state_d = ST_IDLE;
            clk_d   = IDLE_LVL;
          end
        end else begin
          cnt_d  = cnt_inc;
          clk_d  = (cnt_inc >= half);
          lmid_d = (cnt_inc == quarter);
          rise_d = (cnt_inc == half);
          hmid_d = (cnt_inc == hq);
        end
      end
    endcase

    if (apply) begin
      div_d    = pend_q;
      pend_v_d = 1'b0;
    end
    // A write landing on an apply cycle stays pending for the next boundary.
    if (div_we_i) begin
      pend_d   = (div_i < DIV_MIN_W) ? DIV_MIN_W : div_i;
      pend_v_d = 1'b1;
    end
    busy_d = (state_d != ST_IDLE);
  end

  assign clk_o       = clk_q;
  assign fall_o      = fall_q;
  assign low_mid_o   = lmid_q;
  assign rise_o      = rise_q;
  assign high_mid_o  = hmid_q;
  assign busy_o      = busy_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_clk_div_phase.sv
// Bench for clk_div_phase: strobe events scoreboarded against cycle-stamped expectations,
// plus direct level checks of clk_o, busy_o and state.
module tb_clk_div_phase;

  localparam int CNT_W = 16;

  logic             clk_i = 1'b0;
  logic             arstn_i = 1'b0;
  logic             en_i = 1'b0;
  logic [CNT_W-1:0] div_i = '0;
  logic             div_we_i = 1'b0;
  logic             stretch_i = 1'b0;
  logic             clk_o, fall_o, low_mid_o, rise_o, high_mid_o, busy_o;
  logic [1:0]       dbg_state_o;

  clk_div_phase dut (
    .clk_i       (clk_i),
    .arstn_i     (arstn_i),
    .en_i        (en_i),
    .div_i       (div_i),
    .div_we_i    (div_we_i),
    .stretch_i   (stretch_i),
    .clk_o       (clk_o),
    .fall_o      (fall_o),
    .low_mid_o   (low_mid_o),
    .rise_o      (rise_o),
    .high_mid_o  (high_mid_o),
    .busy_o      (busy_o),
    .dbg_state_o (dbg_state_o)
  );

  // ---------------- clock / reset ----------------
  always #5 clk_i = ~clk_i;

  int cyc = 0;
  always @(posedge clk_i) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] exp_q[$];
  logic        mon_en = 1'b0;
  logic [3:0]  strb;
  assign strb = {high_mid_o, rise_o, low_mid_o, fall_o};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Event word: one-hot strobe kind in [31:28], cycle stamp in [27:0].
  function automatic logic [31:0] ev(input logic [3:0] kind, input int c);
    return {kind, c[27:0]};
  endfunction

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk_i) begin
    if (mon_en && (strb != 4'b0)) begin
      if (exp_q.size() == 0) check("extra_strobe", {strb, cyc[27:0]}, 32'h0);
      else                   check("strobe", {strb, cyc[27:0]}, exp_q.pop_front());
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic run_to(input int c);
    while (cyc < c) tick();
  endtask

  task automatic do_reset();
    arstn_i   = 1'b0;
    en_i      = 1'b0;
    div_we_i  = 1'b0;
    stretch_i = 1'b0;
    div_i     = '0;
    mon_en    = 1'b0;
    tick();
    check("rst_clk", {31'd0, clk_o}, 32'd1);
    check("rst_strobes", {28'd0, strb}, 32'd0);
    check("rst_busy", {31'd0, busy_o}, 32'd0);
    check("rst_state", {30'd0, dbg_state_o}, 32'd0);
    tick();
    arstn_i = 1'b1;
    tick();
  endtask

  // Optionally program the divisor while idle, then raise en_i; s = cycle where cnt==0.
  task automatic start_run(input int p, output int s);
    if (p != 0) begin
      div_i    = CNT_W'(p);
      div_we_i = 1'b1;
      tick();
      div_we_i = 1'b0;
      tick();
      tick();
    end
    en_i   = 1'b1;
    mon_en = 1'b1;
    s      = cyc + 1;
  endtask

  task automatic push_period(input int s, input int p);
    int h, q;
    h = p / 2;
    q = p / 4;
    exp_q.push_back(ev(4'b0001, s));
    exp_q.push_back(ev(4'b0010, s + q));
    exp_q.push_back(ev(4'b0100, s + h));
    exp_q.push_back(ev(4'b1000, s + h + q));
  endtask

  task automatic close_window(input int last);
    run_to(last + 1);
    mon_en = 1'b0;
    check("sb_empty", exp_q.size(), 32'd0);
    exp_q.delete();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int s, s2, hi;

    // Default divisor 500: 250 low / 250 high.
    do_reset();
    start_run(0, s);
    push_period(s, 500);
    exp_q.push_back(ev(4'b0001, s + 500));
    run_to(s);
    check("t1_busy", {31'd0, busy_o}, 32'd1);
    check("t1_state", {30'd0, dbg_state_o}, 32'd1);
    check("t1_clk_start", {31'd0, clk_o}, 32'd0);
    run_to(s + 249);
    check("t1_clk_249", {31'd0, clk_o}, 32'd0);
    tick();
    check("t1_clk_250", {31'd0, clk_o}, 32'd1);
    run_to(s + 499);
    check("t1_clk_499", {31'd0, clk_o}, 32'd1);
    close_window(s + 500);

    // Mid-period write of 7: current period unchanged, next two are 3 low / 4 high.
    do_reset();
    start_run(0, s);
    push_period(s, 500);
    push_period(s + 500, 7);
    push_period(s + 507, 7);
    exp_q.push_back(ev(4'b0001, s + 514));
    run_to(s + 100);
    div_i    = 16'd7;
    div_we_i = 1'b1;
    tick();
    div_we_i = 1'b0;
    run_to(s + 499);
    check("t2_clk_499", {31'd0, clk_o}, 32'd1);
    run_to(s + 502);
    check("t2_clk_p7_c2", {31'd0, clk_o}, 32'd0);
    tick();
    check("t2_clk_p7_c3", {31'd0, clk_o}, 32'd1);
    run_to(s + 506);
    check("t2_clk_p7_c6", {31'd0, clk_o}, 32'd1);
    close_window(s + 514);

    // Divisor 2 clamps to 4.
    do_reset();
    start_run(2, s);
    push_period(s, 4);
    push_period(s + 4, 4);
    push_period(s + 8, 4);
    exp_q.push_back(ev(4'b0001, s + 12));
    run_to(s + 1);
    check("t3_clk_c1", {31'd0, clk_o}, 32'd0);
    tick();
    check("t3_clk_c2", {31'd0, clk_o}, 32'd1);
    tick();
    check("t3_clk_c3", {31'd0, clk_o}, 32'd1);
    tick();
    check("t3_clk_c0", {31'd0, clk_o}, 32'd0);
    close_window(s + 12);

    // P=8, stretch for 10 cycles from cnt==4; then stretch at cnt 0..3 is ignored.
    do_reset();
    start_run(8, s);
    exp_q.push_back(ev(4'b0001, s));
    exp_q.push_back(ev(4'b0010, s + 2));
    exp_q.push_back(ev(4'b0100, s + 4));
    exp_q.push_back(ev(4'b1000, s + 16));
    push_period(s + 18, 8);
    exp_q.push_back(ev(4'b0001, s + 26));
    run_to(s);
    hi = 0;
    while (cyc < s + 18) begin
      if (cyc == s + 4)  stretch_i = 1'b1;
      if (cyc == s + 14) stretch_i = 1'b0;
      hi += int'(clk_o);
      tick();
    end
    check("t4_high_len", hi, 32'd14);
    check("t4_clk_wrap", {31'd0, clk_o}, 32'd0);
    stretch_i = 1'b1;
    run_to(s + 22);
    stretch_i = 1'b0;
    close_window(s + 26);

    // P=8, en_i dropped at cnt==2: finish period, go idle high, no extra fall.
    do_reset();
    start_run(8, s);
    push_period(s, 8);
    run_to(s + 2);
    en_i = 1'b0;
    tick();
    check("t5_state_stop", {30'd0, dbg_state_o}, 32'd2);
    run_to(s + 7);
    check("t5_busy_last", {31'd0, busy_o}, 32'd1);
    tick();
    check("t5_busy_idle", {31'd0, busy_o}, 32'd0);
    check("t5_clk_idle", {31'd0, clk_o}, 32'd1);
    check("t5_state_idle", {30'd0, dbg_state_o}, 32'd0);
    run_to(s + 12);
    check("t5_clk_hold", {31'd0, clk_o}, 32'd1);
    close_window(s + 12);

    // en_i dropped and re-raised within a period: periods run back to back.
    do_reset();
    start_run(8, s);
    push_period(s, 8);
    push_period(s + 8, 8);
    exp_q.push_back(ev(4'b0001, s + 16));
    run_to(s + 2);
    en_i = 1'b0;
    run_to(s + 4);
    en_i = 1'b1;
    run_to(s + 8);
    check("t5b_busy", {31'd0, busy_o}, 32'd1);
    close_window(s + 16);

    // Reset at cnt==5 with a pending write: immediate reset values, divisor back to 500.
    do_reset();
    start_run(8, s);
    exp_q.push_back(ev(4'b0001, s));
    exp_q.push_back(ev(4'b0010, s + 2));
    exp_q.push_back(ev(4'b0100, s + 4));
    run_to(s + 4);
    div_i    = 16'd12;
    div_we_i = 1'b1;
    tick();
    div_we_i = 1'b0;
    check("t6_busy_pre", {31'd0, busy_o}, 32'd1);
    arstn_i = 1'b0;
    #1;
    check("t6_clk", {31'd0, clk_o}, 32'd1);
    check("t6_strobes", {28'd0, strb}, 32'd0);
    check("t6_busy", {31'd0, busy_o}, 32'd0);
    check("t6_state", {30'd0, dbg_state_o}, 32'd0);
    mon_en = 1'b0;
    check("t6_sb_empty", exp_q.size(), 32'd0);
    exp_q.delete();
    en_i = 1'b0;
    tick();
    arstn_i = 1'b1;
    tick();
    start_run(0, s2);
    push_period(s2, 500);
    exp_q.push_back(ev(4'b0001, s2 + 500));
    close_window(s2 + 500);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    n_tests++;
    n_fail++;
    $display("FAIL watchdog: simulation did not complete (cycle %0d)", cyc);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
